// File: rtl/pc_sequencer_pkg.sv
// Shared types and default constants for the fetch-address sequencer.
//   state_e : sequencer FSM states (boot bubble, running, halted)
//   kind_e  : redirect kind held in the pending buffer; encoding order is the
//             capture priority (Eret > Br > None), so kinds compare numerically.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    KindNone = 2'd0,
    KindBr   = 2'd1,
    KindEret = 2'd2
  } kind_e;

  localparam logic [31:0] DefResetVec    = 32'h0000_3000;
  localparam logic [31:0] DefExcVec      = 32'h0000_4180;
  localparam int unsigned DefInstrBytes  = 4;
  localparam int unsigned DefBootBubbles = 1;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-sequencer bus: redirect/control requests from ID/EX and CP0 towards the
// sequencer, and the fetch address plus status back to the IF stage.
//   master : redirect/control source (drives requests, observes fetch status)
//   slave  : the sequencer itself
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall;
  logic             br_valid;
  logic [WIDTH-1:0] br_target;
  logic             eret_valid;
  logic [WIDTH-1:0] epc;
  logic             exc_valid;
  logic             halt_req;
  logic             resume;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic             fetch_valid;
  logic             misalign;
  logic             halted;

  modport master (
    output stall, br_valid, br_target, eret_valid, epc, exc_valid, halt_req, resume,
    input  pc, pc_plus, fetch_valid, misalign, halted
  );

  modport slave (
    input  stall, br_valid, br_target, eret_valid, epc, exc_valid, halt_req, resume,
    output pc, pc_plus, fetch_valid, misalign, halted
  );
endinterface

// File: rtl/pc_sequencer_redirect_arbiter.sv
// Combinational next-PC select for the RUN state plus the pending-redirect
// buffer update.
// Ports:
//   stall, exc_valid            : IF stall and exception request
//   br_valid/br_target          : branch/jump redirect
//   eret_valid/epc              : ERET redirect
//   pc, pc_plus                 : current fetch address and its successor
//   pend_kind/pend_target       : current pending-buffer contents
//   next_pc                     : PC to load on the coming edge
//   pend_kind_d/pend_target_d   : pending-buffer contents after the edge
module pc_sequencer_redirect_arbiter
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(DefExcVec)
) (
  input  logic             stall,
  input  logic             exc_valid,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             eret_valid,
  input  logic [WIDTH-1:0] epc,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] pc_plus,
  input  kind_e            pend_kind,
  input  logic [WIDTH-1:0] pend_target,
  output logic [WIDTH-1:0] next_pc,
  output kind_e            pend_kind_d,
  output logic [WIDTH-1:0] pend_target_d
);

  kind_e            req_kind;
  logic [WIDTH-1:0] req_target;

  // Same-cycle ERET and branch: ERET wins.
  always_comb begin
    req_kind   = KindNone;
    req_target = br_target;
    if (eret_valid) begin
      req_kind   = KindEret;
      req_target = epc;
    end else if (br_valid) begin
      req_kind = KindBr;
    end
  end

  always_comb begin
    next_pc       = pc;
    pend_kind_d   = pend_kind;
    pend_target_d = pend_target;
    if (exc_valid) begin
      next_pc     = EXC_VEC;
      pend_kind_d = KindNone;
    end else if (stall) begin
      // Empty buffer (KindNone) always accepts; otherwise an equal or higher
      // priority kind overwrites and a lower one is dropped.
      if (req_kind != KindNone && req_kind >= pend_kind) begin
        pend_kind_d   = req_kind;
        pend_target_d = req_target;
      end
    end else if (eret_valid) begin
      // A live ERET supersedes anything buffered.
      next_pc     = epc;
      pend_kind_d = KindNone;
    end else if (pend_kind != KindNone) begin
      // A new branch arriving here is dropped; the issuer re-requests.
      next_pc     = pend_target;
      pend_kind_d = KindNone;
    end else if (br_valid) begin
      next_pc = br_target;
    end else begin
      next_pc = pc_plus;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer for the pipelined MIPS core. Holds the fetch PC, a
// boot-bubble counter, the BOOT/RUN/HALT state and a one-entry pending
// redirect buffer; next-PC selection in RUN comes from the redirect arbiter.
// Ports:
//   clk    : clock, all state on the rising edge
//   reset  : asynchronous active-low reset
//   bus    : pc_sequencer_if slave (redirect requests in, pc/status out)
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VEC    = WIDTH'(DefResetVec),
  parameter logic [WIDTH-1:0] EXC_VEC      = WIDTH'(DefExcVec),
  parameter int unsigned      INSTR_BYTES  = DefInstrBytes,
  parameter int unsigned      BOOT_BUBBLES = DefBootBubbles
) (
  input logic         clk,
  input logic         reset,
  pc_sequencer_if.slave bus
);

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [3:0]       bubble_q;
  kind_e            pend_kind_q;
  logic [WIDTH-1:0] pend_target_q;

  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] next_pc;
  kind_e            pend_kind_d;
  logic [WIDTH-1:0] pend_target_d;

  assign pc_plus = pc_q + WIDTH'(INSTR_BYTES);

  pc_sequencer_redirect_arbiter #(
    .WIDTH   (WIDTH),
    .EXC_VEC (EXC_VEC)
  ) u_arbiter (
    .stall         (bus.stall),
    .exc_valid     (bus.exc_valid),
    .br_valid      (bus.br_valid),
    .br_target     (bus.br_target),
    .eret_valid    (bus.eret_valid),
    .epc           (bus.epc),
    .pc            (pc_q),
    .pc_plus       (pc_plus),
    .pend_kind     (pend_kind_q),
    .pend_target   (pend_target_q),
    .next_pc       (next_pc),
    .pend_kind_d   (pend_kind_d),
    .pend_target_d (pend_target_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StBoot;
      pc_q          <= RESET_VEC;
      bubble_q      <= 4'(BOOT_BUBBLES);
      pend_kind_q   <= KindNone;
      pend_target_q <= '0;
    end else begin
      unique case (state_q)
        // PC held and exceptions ignored until the bubbles have drained.
        StBoot: begin
          if (bubble_q == 4'd0) begin
            state_q <= StRun;
          end else begin
            bubble_q <= bubble_q - 4'd1;
          end
        end
        StRun: begin
          if (bus.halt_req && !bus.exc_valid) begin
            state_q <= StHalt;
          end else begin
            pc_q          <= next_pc;
            pend_kind_q   <= pend_kind_d;
            pend_target_q <= pend_target_d;
          end
        end
        StHalt: begin
          if (bus.exc_valid) begin
            state_q     <= StRun;
            pc_q        <= EXC_VEC;
            pend_kind_q <= KindNone;
          end else if (bus.resume && !bus.halt_req) begin
            state_q <= StRun;
          end
        end
        default: state_q <= StBoot;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus     = pc_plus;
  assign bus.fetch_valid = (state_q == StRun) && !bus.stall;
  assign bus.misalign    = (pc_q[1:0] != 2'b00);
  assign bus.halted      = (state_q == StHalt);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pc_sequencer_if #(.WIDTH(32)) bus ();

  pc_sequencer #(
    .WIDTH        (32),
    .RESET_VEC    (32'h0000_3000),
    .EXC_VEC      (32'h0000_4180),
    .INSTR_BYTES  (4),
    .BOOT_BUBBLES (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle; inputs set after this are stable for the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.stall      = 1'b0;
    bus.br_valid   = 1'b0;
    bus.br_target  = '0;
    bus.eret_valid = 1'b0;
    bus.epc        = '0;
    bus.exc_valid  = 1'b0;
    bus.halt_req   = 1'b0;
    bus.resume     = 1'b0;

    // Reset state
    step();
    step();
    check32("rst_pc", bus.pc, 32'h0000_3000);
    check32("rst_pc_plus", bus.pc_plus, 32'h0000_3004);
    check1("rst_fv", bus.fetch_valid, 1'b0);
    check1("rst_halted", bus.halted, 1'b0);
    check1("rst_misalign", bus.misalign, 1'b0);

    // First boot, run a little
    reset = 1'b1;
    step();
    step();
    step();
    check32("boot1_pc", bus.pc, 32'h0000_3004);

    // Reset mid-run: async return to reset values
    reset = 1'b0;
    #1;
    check32("midrst_pc", bus.pc, 32'h0000_3000);
    check1("midrst_fv", bus.fetch_valid, 1'b0);
    reset = 1'b1;
    step();
    check1("bubble_fv", bus.fetch_valid, 1'b0);
    check32("bubble_pc", bus.pc, 32'h0000_3000);
    step();
    check1("run_fv", bus.fetch_valid, 1'b1);
    check32("run_pc0", bus.pc, 32'h0000_3000);
    step();
    check32("run_pc1", bus.pc, 32'h0000_3004);
    step();
    check32("run_pc2", bus.pc, 32'h0000_3008);
    step();
    step();
    check32("run_pc4", bus.pc, 32'h0000_3010);

    // Branch under 3-cycle stall
    bus.stall     = 1'b1;
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h0000_3100;
    for (int i = 0; i < 3; i++) begin
      step();
      check32("stall_hold_pc", bus.pc, 32'h0000_3010);
      check1("stall_fv", bus.fetch_valid, 1'b0);
    end
    bus.stall    = 1'b0;
    bus.br_valid = 1'b0;
    step();
    check32("pend_br_pc", bus.pc, 32'h0000_3100);
    step();
    check32("after_br_pc", bus.pc, 32'h0000_3104);

    // Br then ERET under stall; later br dropped
    bus.stall     = 1'b1;
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h0000_3100;
    step();
    bus.br_valid   = 1'b0;
    bus.eret_valid = 1'b1;
    bus.epc        = 32'h0000_3200;
    step();
    bus.eret_valid = 1'b0;
    bus.br_valid   = 1'b1;
    bus.br_target  = 32'h0000_3300;
    step();
    check32("eret_hold_pc", bus.pc, 32'h0000_3104);
    bus.br_valid = 1'b0;
    bus.stall    = 1'b0;
    step();
    check32("pend_eret_pc", bus.pc, 32'h0000_3200);
    step();
    check32("after_eret_pc", bus.pc, 32'h0000_3204);

    // Exception under stall clears pending
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h0000_3020;
    step();
    check32("br_direct_pc", bus.pc, 32'h0000_3020);
    bus.stall     = 1'b1;
    bus.br_target = 32'h0000_3100;
    step();
    bus.br_valid  = 1'b0;
    bus.exc_valid = 1'b1;
    step();
    check32("exc_pc", bus.pc, 32'h0000_4180);
    bus.exc_valid = 1'b0;
    step();
    check32("exc_stall_pc", bus.pc, 32'h0000_4180);
    bus.stall = 1'b0;
    step();
    check32("exc_release_pc", bus.pc, 32'h0000_4184);
    check1("exc_release_fv", bus.fetch_valid, 1'b1);

    // Halt / resume
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h0000_3040;
    step();
    bus.br_valid = 1'b0;
    bus.halt_req = 1'b1;
    step();
    check1("halt_halted", bus.halted, 1'b1);
    check1("halt_fv", bus.fetch_valid, 1'b0);
    check32("halt_pc", bus.pc, 32'h0000_3040);
    bus.halt_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check32("halt_hold_pc", bus.pc, 32'h0000_3040);
    end
    bus.halt_req = 1'b1;
    bus.resume   = 1'b1;
    step();
    check1("halt_both_halted", bus.halted, 1'b1);
    bus.halt_req = 1'b0;
    step();
    check1("resume_halted", bus.halted, 1'b0);
    check32("resume_pc", bus.pc, 32'h0000_3040);
    bus.resume = 1'b0;
    step();
    check32("resume_next_pc", bus.pc, 32'h0000_3044);

    // Exception while halted
    bus.halt_req = 1'b1;
    step();
    check1("halt2_halted", bus.halted, 1'b1);
    bus.halt_req  = 1'b0;
    bus.exc_valid = 1'b1;
    step();
    check1("halt_exc_halted", bus.halted, 1'b0);
    check32("halt_exc_pc", bus.pc, 32'h0000_4180);
    bus.exc_valid = 1'b0;
    step();
    check32("halt_exc_next_pc", bus.pc, 32'h0000_4184);

    // Misaligned target
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h0000_3102;
    step();
    check32("mis_pc", bus.pc, 32'h0000_3102);
    check1("mis_flag", bus.misalign, 1'b1);
    bus.br_target = 32'h0000_3100;
    step();
    check1("aligned_flag", bus.misalign, 1'b0);

    // Wrap-around
    bus.br_target = 32'hFFFF_FFFC;
    step();
    check32("wrap_pc_plus", bus.pc_plus, 32'h0000_0000);
    bus.br_valid = 1'b0;
    step();
    check32("wrap_pc", bus.pc, 32'h0000_0000);

    // Exception during boot is ignored
    reset = 1'b0;
    #1;
    reset         = 1'b1;
    bus.exc_valid = 1'b1;
    step();
    check32("boot_exc_pc", bus.pc, 32'h0000_3000);
    check1("boot_exc_fv", bus.fetch_valid, 1'b0);
    step();
    check32("boot_exc_run_pc", bus.pc, 32'h0000_3000);
    check1("boot_exc_run_fv", bus.fetch_valid, 1'b1);
    bus.exc_valid = 1'b0;
    step();
    check32("boot_exc_next_pc", bus.pc, 32'h0000_3004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
